bus_slave_ctrl: RTL and testbench
=================================

BUS_SLAVE_CTRL -- requirements
Module: bus_slave_ctrl

Interface
REQ-001 The parameters SHALL be: BUS_ADD_WIDTH, default 32, address width; BUS_DAT_WIDTH, default 32, data width; BASE_ADDR, default 32'h0000_1000, slave window base; REG_NUM, default 16, number of words (power of 2); WAIT_CYCLES, default 2, wait states inserted before acknowledge (0..15).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 s_addr_i  input  BUS_ADD_WIDTH  byte address from the master mux.
REQ-006 s_addr_cs_i  input  1  chip select; the master holds it high until s_rdy_o is seen.
REQ-007 s_rw_i  input  1  1 = read, 0 = write.
REQ-008 s_wr_data_i  input  BUS_DAT_WIDTH  write data.
REQ-009 s_rd_data_o  output  BUS_DAT_WIDTH  read data, valid only while s_rdy_o=1 on a read.
REQ-010 s_rdy_o  output  1  one-cycle transfer-complete pulse.
REQ-011 s_err_o  output  1  one-cycle error pulse, coincident with s_rdy_o.

Function
REQ-012 Hit SHALL be s_addr_cs_i=1 and s_addr_i[BUS_ADD_WIDTH-1:log2(REG_NUM)+2] equal to the same bits of BASE_ADDR; word index SHALL be s_addr_i[log2(REG_NUM)+1:2].
REQ-013 The FSM states SHALL be IDLE, WAIT and ACK.
REQ-014 IDLE: on hit, capture index, rw and wr_data, and load the wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else go to ACK. With no hit, stay in IDLE.
REQ-015 WAIT: decrement the counter each cycle; go to ACK when the counter reaches 1. If s_addr_cs_i drops, abort to IDLE with no write and no s_rdy_o.
REQ-016 ACK: assert s_rdy_o for exactly one cycle; a write SHALL update the addressed word at the clock edge ending ACK; a read SHALL drive that word on s_rd_data_o in the same cycle; then go to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: s_rdy_o is asserted WAIT_CYCLES+1 cycles after the cycle in which the hit is sampled in IDLE.
REQ-018 A new transfer SHALL be sampled no earlier than the cycle after ACK, giving a minimum of WAIT_CYCLES+2 cycles per transfer.
REQ-019 s_rd_data_o SHALL be 0 whenever s_rdy_o=0 or the transfer is a write.
REQ-020 Address changes during WAIT SHALL be ignored; the captured values are used.
REQ-021 A non-hit address SHALL produce no response.

Reset
REQ-022 On rst_i: state=IDLE, counter=0, s_rdy_o=0, s_err_o=0, s_rd_data_o=0, and all REG_NUM words=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer, with no write and no s_rdy_o after release.

Configuration
REQ-024 With macro BUS_SLAVE_ERR_EN defined, a hit with s_addr_i[1:0]!=0 SHALL complete with s_rdy_o=1 and s_err_o=1, performing no write and returning read data 0.
REQ-025 Without BUS_SLAVE_ERR_EN, s_err_o SHALL be tied 0 and s_addr_i[1:0] SHALL be ignored.

Structure
REQ-026 Package bus_pkg SHALL hold the FSM state enum (IDLE/WAIT/ACK), the RW_READ/RW_WRITE constants and the default width constants shared with bus_master_mux users.
REQ-027 The word storage SHALL be a sub-module bus_slave_regfile (REG_NUM x BUS_DAT_WIDTH, one combinational read port, one synchronous write port, async reset to 0).

Verification
REQ-028 Write then read: write 32'hDEAD_BEEF to 0x1008, then read 0x1008 with WAIT_CYCLES=2 -> s_rdy_o pulses 3 cycles after each sample, and the read returns DEAD_BEEF.
REQ-029 Zero wait: WAIT_CYCLES=0, read 0x1000 after reset -> s_rdy_o on the next cycle with data 0.
REQ-030 Miss: cs=1 with address 0x2000 for 10 cycles -> s_rdy_o stays 0 and no word changes.
REQ-031 Abort: write to 0x1004 with cs dropped in WAIT -> no s_rdy_o, and a following read of 0x1004 returns 0.
REQ-032 Misalignment: with BUS_SLAVE_ERR_EN, write 0x1006 -> s_rdy_o=1 and s_err_o=1, and a read of 0x1004 returns 0; without the macro, the same write updates word 1.
REQ-033 Reset mid-WAIT: assert rst_i during a write to 0x100C -> outputs are 0 and a subsequent read of 0x100C returns 0.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the simple memory-mapped bus: slave FSM state
// encoding, read/write direction constants and the default bus widths used
// by bus_slave_ctrl and the bus_master_mux users.
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int          BUS_ADD_WIDTH_DEF = 32;
  localparam int          BUS_DAT_WIDTH_DEF = 32;
  localparam logic [31:0] BASE_ADDR_DEF     = 32'h0000_1000;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_slave_regfile.sv
// -----------------------------------------------------------------------------
// bus_slave_regfile
// REG_NUM x BUS_DAT_WIDTH word storage for bus_slave_ctrl.
// One combinational read port, one synchronous write port, all words cleared
// by the asynchronous active-high reset.
//
// Ports:
//   clk_i    : rising-edge clock
//   rst_i    : asynchronous active-high reset
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index
//   rdata_o  : read data (combinational)
// -----------------------------------------------------------------------------
module bus_slave_regfile #(
  parameter int BUS_DAT_WIDTH = 32,
  parameter int REG_NUM       = 16,
  parameter int IDX_W         = $clog2(REG_NUM)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         waddr_i,
  input  logic [BUS_DAT_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]         raddr_i,
  output logic [BUS_DAT_WIDTH-1:0] rdata_o
);

  logic [BUS_DAT_WIDTH-1:0] regs_q [REG_NUM];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/bus_slave_ctrl.sv
// -----------------------------------------------------------------------------
// bus_slave_ctrl
// Memory-mapped register slave with a fixed number of wait states. A hit in
// IDLE captures index/direction/data, waits WAIT_CYCLES cycles, then answers
// with a one-cycle s_rdy_o in ACK (write commits at the edge ending ACK).
//
// Optional feature: define BUS_SLAVE_ERR_EN to flag hits with a misaligned
// byte address (s_addr_i[1:0] != 0); they complete with s_rdy_o and s_err_o,
// perform no write and return zero. Without it s_err_o is tied low and the
// two low address bits are ignored.
//
// Ports:
//   clk_i        : rising-edge clock
//   rst_i        : asynchronous active-high reset
//   s_addr_i     : byte address from the master mux
//   s_addr_cs_i  : chip select, held high by the master until s_rdy_o
//   s_rw_i       : 1 = read, 0 = write
//   s_wr_data_i  : write data
//   s_rd_data_o  : read data, non-zero only during s_rdy_o of a read
//   s_rdy_o      : one-cycle transfer-complete pulse
//   s_err_o      : one-cycle error pulse, coincident with s_rdy_o
// -----------------------------------------------------------------------------
module bus_slave_ctrl
  import bus_pkg::*;
#(
  parameter int                       BUS_ADD_WIDTH = BUS_ADD_WIDTH_DEF,
  parameter int                       BUS_DAT_WIDTH = BUS_DAT_WIDTH_DEF,
  parameter logic [BUS_ADD_WIDTH-1:0] BASE_ADDR     = BUS_ADD_WIDTH'(BASE_ADDR_DEF),
  parameter int                       REG_NUM       = 16,
  parameter int                       WAIT_CYCLES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BUS_ADD_WIDTH-1:0] s_addr_i,
  input  logic                     s_addr_cs_i,
  input  logic                     s_rw_i,
  input  logic [BUS_DAT_WIDTH-1:0] s_wr_data_i,
  output logic [BUS_DAT_WIDTH-1:0] s_rd_data_o,
  output logic                     s_rdy_o,
  output logic                     s_err_o
);

  localparam int         IDX_W     = $clog2(REG_NUM);
  localparam int         TAG_LSB   = IDX_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  bus_state_e               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     rw_q, rw_d;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BUS_DAT_WIDTH-1:0] wdata_q, wdata_d;

  logic                     hit;
  logic                     misal;
  logic                     we;
  logic [BUS_DAT_WIDTH-1:0] rdata;

  // Only the bits above the word index form the window tag.
  assign hit = s_addr_cs_i &&
               (s_addr_i[BUS_ADD_WIDTH-1:TAG_LSB] == BASE_ADDR[BUS_ADD_WIDTH-1:TAG_LSB]);

`ifdef BUS_SLAVE_ERR_EN
  assign misal   = |s_addr_i[1:0];
  assign s_err_o = (state_q == ACK) && err_q;
`else
  logic unused_addr_lsb;
  assign misal           = 1'b0;
  assign unused_addr_lsb = ^s_addr_i[1:0];
  assign s_err_o         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          idx_d   = s_addr_i[TAG_LSB-1:2];
          rw_d    = s_rw_i;
          wdata_d = s_wr_data_i;
          err_d   = misal;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        // Dropping chip select abandons the transfer before anything commits.
        if (!s_addr_cs_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  // Captured index/data are only consumed in ACK, which is always preceded by
  // a capture, so they need no reset.
  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  assign we          = (state_q == ACK) && (rw_q == RW_WRITE) && !err_q;
  assign s_rdy_o     = (state_q == ACK);
  assign s_rd_data_o = ((state_q == ACK) && (rw_q == RW_READ) && !err_q) ? rdata : '0;

  bus_slave_regfile #(
    .BUS_DAT_WIDTH (BUS_DAT_WIDTH),
    .REG_NUM       (REG_NUM),
    .IDX_W         (IDX_W)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_ctrl
// Directed bench for bus_slave_ctrl. Two instances share one master: dut_w2
// (WAIT_CYCLES=2) and dut_w0 (WAIT_CYCLES=0); sel_w0 steers chip select and
// selects which instance's response is observed.
// -----------------------------------------------------------------------------
module tb_bus_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_addr;
  logic        m_cs;
  logic        m_rw;
  logic [31:0] m_wd;
  logic        sel_w0;

  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0, err2, err0;
  logic [31:0] rd_m;
  logic        rdy_m, err_m;

  int n_checks = 0;
  int n_fail   = 0;
  int bad_rd   = 0;

  always #5 clk = ~clk;

  bus_slave_ctrl #(
    .WAIT_CYCLES (2)
  ) dut_w2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_addr_i    (m_addr),
    .s_addr_cs_i (m_cs & ~sel_w0),
    .s_rw_i      (m_rw),
    .s_wr_data_i (m_wd),
    .s_rd_data_o (rd2),
    .s_rdy_o     (rdy2),
    .s_err_o     (err2)
  );

  bus_slave_ctrl #(
    .WAIT_CYCLES (0)
  ) dut_w0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_addr_i    (m_addr),
    .s_addr_cs_i (m_cs & sel_w0),
    .s_rw_i      (m_rw),
    .s_wr_data_i (m_wd),
    .s_rd_data_o (rd0),
    .s_rdy_o     (rdy0),
    .s_err_o     (err0)
  );

  assign rd_m  = sel_w0 ? rd0  : rd2;
  assign rdy_m = sel_w0 ? rdy0 : rdy2;
  assign err_m = sel_w0 ? err0 : err2;

  // Read data must stay zero whenever no transfer is being acknowledged.
  always @(negedge clk) begin
    if ((!rdy2 && rd2 != 32'h0) || (!rdy0 && rd0 != 32'h0)) bad_rd++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge. Returns the number of edges from
  // the sampling edge to the one after which s_rdy_o is seen (0 = timeout).
  task automatic xfer(input logic sel, input logic [31:0] addr, input logic rw,
                      input logic [31:0] wd, output int lat,
                      output logic [31:0] rd, output logic er);
    sel_w0 = sel;
    m_addr = addr;
    m_rw   = rw;
    m_wd   = wd;
    m_cs   = 1'b1;
    lat    = 0;
    rd     = 32'h0;
    er     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rdy_m) begin
        lat = i;
        rd  = rd_m;
        er  = err_m;
        break;
      end
    end
    m_cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input string tag, input logic sel, input logic [31:0] addr,
                          input logic [31:0] exp);
    int          lat;
    logic [31:0] rd;
    logic        er;
    xfer(sel, addr, 1'b1, 32'h0, lat, rd, er);
    check_eq({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
    check_eq({tag, "_data"}, rd, exp);
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [31:0] rd;
    logic        er;

    rst    = 1'b1;
    m_cs   = 1'b0;
    m_addr = 32'h0;
    m_rw   = 1'b1;
    m_wd   = 32'h0;
    sel_w0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rdy",  {31'h0, rdy2}, 32'h0);
    check_eq("reset_err",  {31'h0, err2}, 32'h0);
    check_eq("reset_rd",   rd2, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait instance: answer on the next cycle.
    rd_check("zw_read_1000", 1'b1, 32'h0000_1000, 32'h0);
    xfer(1'b1, 32'h0000_103C, 1'b0, 32'hCAFE_F00D, lat, rd, er);
    check_eq("zw_write_lat", 32'(lat), 32'd1);
    rd_check("zw_read_103C", 1'b1, 32'h0000_103C, 32'hCAFE_F00D);

    // Write then read with two wait states.
    xfer(1'b0, 32'h0000_1008, 1'b0, 32'hDEAD_BEEF, lat, rd, er);
    check_eq("wr1008_lat", 32'(lat), 32'd3);
    check_eq("wr1008_rd_zero", rd, 32'h0);
    check_eq("wr1008_err", {31'h0, er}, 32'h0);
    rd_check("rd1008", 1'b0, 32'h0000_1008, 32'hDEAD_BEEF);

    // Miss: address outside the window held for 10 cycles.
    sel_w0 = 1'b0;
    m_addr = 32'h0000_2000;
    m_rw   = 1'b0;
    m_wd   = 32'hFFFF_FFFF;
    m_cs   = 1'b1;
    cnt    = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy2) cnt++;
    end
    m_cs = 1'b0;
    @(posedge clk); #1;
    check_eq("miss_no_rdy", 32'(cnt), 32'd0);
    rd_check("miss_rd1000", 1'b0, 32'h0000_1000, 32'h0);
    rd_check("miss_rd1008", 1'b0, 32'h0000_1008, 32'hDEAD_BEEF);

    // Abort: chip select dropped while waiting.
    m_addr = 32'h0000_1004;
    m_rw   = 1'b0;
    m_wd   = 32'h1234_5678;
    m_cs   = 1'b1;
    @(posedge clk); #1;
    m_cs = 1'b0;
    cnt  = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy2) cnt++;
    end
    check_eq("abort_no_rdy", 32'(cnt), 32'd0);
    rd_check("abort_rd1004", 1'b0, 32'h0000_1004, 32'h0);

    // Address, direction and data changes during WAIT are ignored.
    m_addr = 32'h0000_1014;
    m_rw   = 1'b0;
    m_wd   = 32'h1111_2222;
    m_cs   = 1'b1;
    @(posedge clk); #1;
    m_addr = 32'h0000_1018;
    m_rw   = 1'b1;
    m_wd   = 32'h3333_4444;
    lat    = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rdy2) begin
        lat = i;
        break;
      end
    end
    m_cs = 1'b0;
    @(posedge clk); #1;
    check_eq("chg_lat", 32'(lat), 32'd3);
    rd_check("chg_rd1014", 1'b0, 32'h0000_1014, 32'h1111_2222);
    rd_check("chg_rd1018", 1'b0, 32'h0000_1018, 32'h0);

    // Misaligned write to 0x1006.
    xfer(1'b0, 32'h0000_1006, 1'b0, 32'hA5A5_5A5A, lat, rd, er);
    check_eq("mis_lat", 32'(lat), 32'd3);
`ifdef BUS_SLAVE_ERR_EN
    check_eq("mis_err", {31'h0, er}, 32'h1);
    rd_check("mis_rd1004", 1'b0, 32'h0000_1004, 32'h0);
`else
    check_eq("mis_err", {31'h0, er}, 32'h0);
    rd_check("mis_rd1004", 1'b0, 32'h0000_1004, 32'hA5A5_5A5A);
`endif

    // Reset in the middle of a write to 0x100C.
    m_addr = 32'h0000_100C;
    m_rw   = 1'b0;
    m_wd   = 32'h5555_AAAA;
    m_cs   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rstmid_rdy", {31'h0, rdy2}, 32'h0);
    check_eq("rstmid_err", {31'h0, err2}, 32'h0);
    check_eq("rstmid_rd",  rd2, 32'h0);
    m_cs = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy2) cnt++;
    end
    check_eq("rstmid_no_rdy", 32'(cnt), 32'd0);
    rd_check("rstmid_rd100C", 1'b0, 32'h0000_100C, 32'h0);
    rd_check("rstmid_rd1008", 1'b0, 32'h0000_1008, 32'h0);

    check_eq("rd_zero_when_idle", 32'(bad_rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
